// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the gpio_ip register port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface gpio_bus_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m1_req;
   logic              m0_we;
   logic              m1_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic [DATA_W-1:0] m1_wdata;
   logic              m0_gnt;
   logic              m1_gnt;
   logic              m0_rvalid;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m0_rdata;
   logic [DATA_W-1:0] m1_rdata;
   logic              gpio_wr_en;
   logic              gpio_rd_en;
   logic [ADDR_W-1:0] gpio_addr;
   logic [DATA_W-1:0] gpio_wdata;
   logic [DATA_W-1:0] gpio_rdata;
   logic              busy;

   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, gpio_rdata,
      output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
             gpio_wr_en, gpio_rd_en, gpio_addr, gpio_wdata, busy
   );

   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, gpio_rdata,
      input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
             gpio_wr_en, gpio_rd_en, gpio_addr, gpio_wdata, busy
   );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin two-master sequencer for the gpio_ip register port: one transaction at a time,
// single-cycle strobes, read data returned to the owner after RD_LAT wait cycles.
module gpio_bus_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input logic               clk,
   input logic               rst_n,
   gpio_bus_arbiter_if.slave bus
);

   localparam int               CNT_W    = 3;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t             r_state;
   logic               r_lastM1;
   logic               r_ownerM1;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_m0Gnt;
   logic               r_m1Gnt;
   logic               r_m0Rvalid;
   logic               r_m1Rvalid;
   logic [DATA_W-1:0]  r_m0Rdata;
   logic [DATA_W-1:0]  r_m1Rdata;
   logic               r_wrEn;
   logic               r_rdEn;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_busy;

   logic               w_anyReq;
   logic               w_pickM1;
   logic               w_selWe;
   logic [ADDR_W-1:0]  w_selAddr;
   logic [DATA_W-1:0]  w_selWdata;

   // m1 wins when alone, or on a tie when m0 was the most recent grant
   assign w_anyReq   = bus.m0_req | bus.m1_req;
   assign w_pickM1   = bus.m1_req & (~bus.m0_req | ~r_lastM1);
   assign w_selWe    = w_pickM1 ? bus.m1_we    : bus.m0_we;
   assign w_selAddr  = w_pickM1 ? bus.m1_addr  : bus.m0_addr;
   assign w_selWdata = w_pickM1 ? bus.m1_wdata : bus.m0_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_lastM1   <= 1'b1;
         r_ownerM1  <= 1'b0;
         r_cnt      <= '0;
         r_m0Gnt    <= 1'b0;
         r_m1Gnt    <= 1'b0;
         r_m0Rvalid <= 1'b0;
         r_m1Rvalid <= 1'b0;
         r_m0Rdata  <= '0;
         r_m1Rdata  <= '0;
         r_wrEn     <= 1'b0;
         r_rdEn     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_m0Gnt    <= 1'b0;
         r_m1Gnt    <= 1'b0;
         r_m0Rvalid <= 1'b0;
         r_m1Rvalid <= 1'b0;
         r_wrEn     <= 1'b0;
         r_rdEn     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_state   <= ISSUE;
                  r_busy    <= 1'b1;
                  r_ownerM1 <= w_pickM1;
                  r_lastM1  <= w_pickM1;
                  r_m0Gnt   <= ~w_pickM1;
                  r_m1Gnt   <= w_pickM1;
                  r_wrEn    <= w_selWe;
                  r_rdEn    <= ~w_selWe;
                  r_addr    <= w_selAddr;
                  r_wdata   <= w_selWe ? w_selWdata : '0;
               end
            end
            ISSUE: begin
               if (r_rdEn) begin
                  r_state <= WAIT;
                  r_cnt   <= '0;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            WAIT: begin
               if (r_cnt == LAST_CNT) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  if (r_ownerM1) begin
                     r_m1Rdata  <= bus.gpio_rdata;
                     r_m1Rvalid <= 1'b1;
                  end else begin
                     r_m0Rdata  <= bus.gpio_rdata;
                     r_m0Rvalid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m0_gnt     = r_m0Gnt;
   assign bus.m1_gnt     = r_m1Gnt;
   assign bus.m0_rvalid  = r_m0Rvalid;
   assign bus.m1_rvalid  = r_m1Rvalid;
   assign bus.m0_rdata   = r_m0Rdata;
   assign bus.m1_rdata   = r_m1Rdata;
   assign bus.gpio_wr_en = r_wrEn;
   assign bus.gpio_rd_en = r_rdEn;
   assign bus.gpio_addr  = r_addr;
   assign bus.gpio_wdata = r_wdata;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: instance A runs with RD_LAT=1, instance B with RD_LAT=4,
// each in front of a small gpio_ip register model (DATA 0x00, DIR 0x04, IN 0x08).
module tb_gpio_bus_arbiter;

   localparam logic [31:0] GPIO_IN = 32'hA5A5A5A5;

   logic clk = 1'b0;
   logic rst_n;
   int   vectorCount = 0;
   int   missCount   = 0;

   always #5 clk = ~clk;

   gpio_bus_arbiter_if #(.ADDR_W(8), .DATA_W(32)) busA ();
   gpio_bus_arbiter_if #(.ADDR_W(8), .DATA_W(32)) busB ();

   gpio_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
   gpio_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

   logic [31:0] regDataA = '0;
   logic [31:0] regDirA  = '0;
   logic [31:0] pipeA    = '0;
   logic [31:0] regDataB = '0;
   logic [31:0] regDirB  = '0;
   logic [31:0] pipeB [4] = '{default: '0};

   function automatic logic [31:0] regRead(input logic [7:0] a, input logic [31:0] d, input logic [31:0] dir);
      case (a)
         8'h00:   return d;
         8'h04:   return dir;
         8'h08:   return GPIO_IN;
         default: return 32'h0;
      endcase
   endfunction

   // Register models: read data appears RD_LAT cycles after the strobe and is zero otherwise,
   // so a capture at the wrong cycle returns 0 instead of the register value
   always @(posedge clk) begin
      if (busA.gpio_wr_en && busA.gpio_addr == 8'h00) regDataA <= busA.gpio_wdata;
      if (busA.gpio_wr_en && busA.gpio_addr == 8'h04) regDirA  <= busA.gpio_wdata;
      pipeA <= busA.gpio_rd_en ? regRead(busA.gpio_addr, regDataA, regDirA) : 32'h0;
      if (busB.gpio_wr_en && busB.gpio_addr == 8'h00) regDataB <= busB.gpio_wdata;
      if (busB.gpio_wr_en && busB.gpio_addr == 8'h04) regDirB  <= busB.gpio_wdata;
      pipeB[0] <= busB.gpio_rd_en ? regRead(busB.gpio_addr, regDataB, regDirB) : 32'h0;
      pipeB[1] <= pipeB[0];
      pipeB[2] <= pipeB[1];
      pipeB[3] <= pipeB[2];
   end

   assign busA.gpio_rdata = pipeA;
   assign busB.gpio_rdata = pipeB[3];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one master of one instance (inst 0 = A, 1 = B)
   task automatic applyStimulus(input int inst, input int master, input logic req, input logic we,
                                input logic [7:0] addr, input logic [31:0] wdata);
      if (inst == 0 && master == 0) begin
         busA.m0_req = req; busA.m0_we = we; busA.m0_addr = addr; busA.m0_wdata = wdata;
      end else if (inst == 0) begin
         busA.m1_req = req; busA.m1_we = we; busA.m1_addr = addr; busA.m1_wdata = wdata;
      end else if (master == 0) begin
         busB.m0_req = req; busB.m0_we = we; busB.m0_addr = addr; busB.m0_wdata = wdata;
      end else begin
         busB.m1_req = req; busB.m1_we = we; busB.m1_addr = addr; busB.m1_wdata = wdata;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_flagsA"}, 32'({busA.m0_gnt, busA.m1_gnt, busA.m0_rvalid, busA.m1_rvalid,
                                        busA.gpio_wr_en, busA.gpio_rd_en, busA.busy}), 32'h0);
      checkOutput({tag, "_flagsB"}, 32'({busB.m0_gnt, busB.m1_gnt, busB.m0_rvalid, busB.m1_rvalid,
                                        busB.gpio_wr_en, busB.gpio_rd_en, busB.busy}), 32'h0);
      checkOutput({tag, "_rdataA"}, busA.m0_rdata | busA.m1_rdata, 32'h0);
      checkOutput({tag, "_rdataB"}, busB.m0_rdata | busB.m1_rdata, 32'h0);
      checkOutput({tag, "_busA"}, 32'(busA.gpio_addr) | busA.gpio_wdata, 32'h0);
      checkOutput({tag, "_busB"}, 32'(busB.gpio_addr) | busB.gpio_wdata, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, i, 1'b0, 1'b0, 8'h00, 32'h0);
         applyStimulus(1, i, 1'b0, 1'b0, 8'h00, 32'h0);
      end
      tick();
      tick();
      checkQuiet("reset");
      rst_n = 1'b1;
      tick();

      // Single write on A: m0 writes DIR = 0xFF
      applyStimulus(0, 0, 1'b1, 1'b1, 8'h04, 32'h0000_00FF);
      tick();
      checkOutput("wr_gnt",   32'({busA.m0_gnt, busA.m1_gnt}), 32'h2);
      checkOutput("wr_strb",  32'({busA.gpio_wr_en, busA.gpio_rd_en}), 32'h2);
      checkOutput("wr_addr",  32'(busA.gpio_addr), 32'h04);
      checkOutput("wr_wdata", busA.gpio_wdata, 32'h0000_00FF);
      checkOutput("wr_busy",  32'(busA.busy), 32'h1);
      applyStimulus(0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      checkOutput("wr_done",  32'({busA.m0_gnt, busA.gpio_wr_en, busA.busy}), 32'h0);
      checkOutput("wr_idleAddr", 32'(busA.gpio_addr), 32'h0);

      // Read on A with RD_LAT=1: m1 reads IN
      applyStimulus(0, 1, 1'b1, 1'b0, 8'h08, 32'h0);
      tick();
      checkOutput("rd_gnt",   32'({busA.m0_gnt, busA.m1_gnt}), 32'h1);
      checkOutput("rd_strb",  32'({busA.gpio_wr_en, busA.gpio_rd_en}), 32'h1);
      checkOutput("rd_addr",  32'(busA.gpio_addr), 32'h08);
      checkOutput("rd_wdata", busA.gpio_wdata, 32'h0);
      applyStimulus(0, 1, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      checkOutput("rd_wait",  32'({busA.m1_rvalid, busA.gpio_rd_en, busA.busy}), 32'h1);
      tick();
      checkOutput("rd_rvalid", 32'({busA.m0_rvalid, busA.m1_rvalid, busA.busy}), 32'h2);
      checkOutput("rd_m1data", busA.m1_rdata, GPIO_IN);
      checkOutput("rd_m0data", busA.m0_rdata, 32'h0);
      tick();
      checkOutput("rd_pulse", 32'(busA.m1_rvalid), 32'h0);
      checkOutput("rd_hold",  busA.m1_rdata, GPIO_IN);

      // Tie on A from reset: grants alternate m0, m1 every two cycles
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      applyStimulus(0, 0, 1'b1, 1'b1, 8'h00, 32'h0000_00AA);
      applyStimulus(0, 1, 1'b1, 1'b1, 8'h00, 32'h0000_0055);
      for (int k = 0; k < 8; k++) begin
         tick();
         checkOutput($sformatf("tie_gnt%0d", k), 32'({busA.m0_gnt, busA.m1_gnt}),
                     (k % 4 == 0) ? 32'h2 : (k % 4 == 2) ? 32'h1 : 32'h0);
         checkOutput($sformatf("tie_wdata%0d", k), busA.gpio_wdata,
                     (k % 4 == 0) ? 32'hAA : (k % 4 == 2) ? 32'h55 : 32'h0);
      end
      applyStimulus(0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
      applyStimulus(0, 1, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();

      // Latency sweep on B (RD_LAT=4): write DATA then read it back
      applyStimulus(1, 0, 1'b1, 1'b1, 8'h00, 32'h0000_00AA);
      tick();
      checkOutput("lat_wrgnt", 32'({busB.m0_gnt, busB.gpio_wr_en}), 32'h3);
      applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      applyStimulus(1, 0, 1'b1, 1'b0, 8'h00, 32'h0);
      tick();
      checkOutput("lat_rdgnt", 32'({busB.m0_gnt, busB.gpio_rd_en}), 32'h3);
      applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 32'h0);
      for (int j = 1; j <= 4; j++) begin
         tick();
         checkOutput($sformatf("lat_wait%0d", j),
                     32'({busB.m0_rvalid, busB.m0_gnt, busB.m1_gnt, busB.busy}), 32'h1);
         if (j == 1) applyStimulus(1, 0, 1'b1, 1'b0, 8'h04, 32'h0);
      end
      tick();
      checkOutput("lat_rvalid", 32'({busB.m0_rvalid, busB.m0_gnt, busB.busy}), 32'h4);
      checkOutput("lat_rdata",  busB.m0_rdata, 32'h0000_00AA);
      tick();
      checkOutput("lat_late_gnt", 32'({busB.m0_gnt, busB.gpio_rd_en}), 32'h3);
      checkOutput("lat_late_addr", 32'(busB.gpio_addr), 32'h04);
      applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 32'h0);

      // Reset in the middle of the WAIT phase aborts the read
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_flags", 32'({busB.busy, busB.gpio_rd_en, busB.m0_rvalid}), 32'h0);
      checkOutput("abort_rdata", busB.m0_rdata, 32'h0);
      for (int j = 0; j < 2; j++) begin
         tick();
         checkOutput($sformatf("abort_rv%0d", j), 32'({busB.m0_rvalid, busB.m1_rvalid}), 32'h0);
      end
      rst_n = 1'b1;
      tick();

      // Pointer back at m1 after reset: tie goes to m0, m1 follows at the next IDLE sample
      applyStimulus(1, 0, 1'b1, 1'b1, 8'h00, 32'h0000_0011);
      applyStimulus(1, 1, 1'b1, 1'b0, 8'h08, 32'h0);
      tick();
      checkOutput("post_tie", 32'({busB.m0_gnt, busB.m1_gnt}), 32'h2);
      applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      checkOutput("post_idle", 32'({busB.m0_gnt, busB.m1_gnt}), 32'h0);
      tick();
      checkOutput("post_m1gnt", 32'({busB.m1_gnt, busB.gpio_rd_en}), 32'h3);
      checkOutput("post_m1addr", 32'(busB.gpio_addr), 32'h08);
      applyStimulus(1, 1, 1'b0, 1'b0, 8'h00, 32'h0);
      for (int j = 0; j < 4; j++) tick();
      tick();
      checkOutput("post_rvalid", 32'({busB.m0_rvalid, busB.m1_rvalid}), 32'h1);
      checkOutput("post_rdata",  busB.m1_rdata, GPIO_IN);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
